// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the packed 24-bit RGB pixel stream.
// Used by the pixel generator, its packer and pixel_unpacker.
//   X_SIZE_DEF / Y_SIZE_DEF : default frame geometry
//   R_LANE / G_LANE / B_LANE: byte position of each colour inside a pixel
//   TKEEP_FULL              : only legal tkeep value on the stream
package pixel_stream_pkg;

  localparam int unsigned X_SIZE_DEF = 640;
  localparam int unsigned Y_SIZE_DEF = 480;

  localparam int unsigned R_LANE = 0;
  localparam int unsigned G_LANE = 1;
  localparam int unsigned B_LANE = 2;

  localparam logic [3:0] TKEEP_FULL = 4'hF;

  localparam int unsigned BUF_BYTES = 6;

  // Largest whole-pixel byte count not exceeding n (n is 0..7).
  function automatic logic [2:0] trunc3(input logic [2:0] n);
    if (n >= 3'd6) begin
      return 3'd6;
    end else if (n >= 3'd3) begin
      return 3'd3;
    end
    return 3'd0;
  endfunction

endpackage

// File: rtl/byte_realign_buf.sv
// Six-byte shift store that realigns 4-byte stream words into 3-byte pixels.
// Oldest byte lives at index 0.
//   aclk, aresetn : clock, asynchronous active-low reset
//   pop3          : drop the three oldest bytes
//   push4         : append push_data (lane 0 first) after any pop/flush
//   flush         : discard all stored bytes before the push
//   truncate      : after the push, round count down to a whole pixel
//   head          : bytes 2..0 packed as {b2, b1, b0}
//   count         : number of stored bytes, 0..6
module byte_realign_buf
  import pixel_stream_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        pop3,
  input  logic        push4,
  input  logic        flush,
  input  logic        truncate,
  input  logic [31:0] push_data,
  output logic [23:0] head,
  output logic [2:0]  count
);

  logic [BUF_BYTES-1:0][7:0] mem_q, mem_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [2:0]                base;
  logic [2:0]                off;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    base  = cnt_q;
    off   = '0;
    if (flush) begin
      base = '0;
    end else if (pop3) begin
      for (int unsigned i = 0; i < 3; i++) begin
        mem_d[i] = mem_q[i+3];
      end
      base = cnt_q - 3'd3;
    end
    cnt_d = base;
    if (push4) begin
      // Slot j takes word lane (j - base); negative offsets wrap above 3 and are skipped.
      for (int unsigned j = 0; j < BUF_BYTES; j++) begin
        off = 3'(j) - base;
        if (off < 3'd4) begin
          mem_d[j] = push_data[{off[1:0], 3'b000} +: 8];
        end
      end
      cnt_d = base + 3'd4;
    end
    if (truncate) begin
      cnt_d = trunc3(cnt_d);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = {mem_q[2], mem_q[1], mem_q[0]};
  assign count = cnt_q;

endmodule

// File: rtl/pixel_unpacker.sv
// AXI4-Stream sink recovering one 24-bit RGB pixel per transfer from the
// packed stream (4 pixels in 3 words, tuser = start of frame, tlast = end of line).
//   aclk, aresetn       : clock, asynchronous active-low reset
//   in_stream_*         : packed input stream (tdata lane 0 = oldest byte)
//   r, g, b, valid      : current pixel, handed off when valid & ready
//   sof, eol            : current pixel is first of frame / last of line
//   x, y                : coordinates of the current pixel
//   err                 : one-cycle pulse on any framing error
module pixel_unpacker
  import pixel_stream_pkg::*;
#(
  parameter int unsigned X_SIZE = X_SIZE_DEF,
  parameter int unsigned Y_SIZE = Y_SIZE_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        valid,
  input  logic        ready,
  output logic        sof,
  output logic        eol,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        err
);

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  logic        sof_pending_q, sof_pending_d;
  logic        eol_pending_q, eol_pending_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        err_q, err_d;

  logic [23:0] head;
  logic [2:0]  cnt;
  logic        fire, accept, flush, truncate;
  logic [2:0]  cnt_after_pop, cnt_after_push;

  byte_realign_buf u_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .pop3      (fire),
    .push4     (accept),
    .flush     (flush),
    .truncate  (truncate),
    .push_data (in_stream_tdata),
    .head      (head),
    .count     (cnt)
  );

  assign valid = (cnt >= 3'd3);
  assign fire  = valid & ready;
  assign r     = head[8*R_LANE +: 8];
  assign g     = head[8*G_LANE +: 8];
  assign b     = head[8*B_LANE +: 8];
  assign sof   = sof_pending_q & valid;
  assign eol   = eol_pending_q & (cnt == 3'd3);
  assign x     = sof ? '0 : x_q;
  assign y     = sof ? '0 : y_q;
  assign err   = err_q;

  // A pop frees room in the same cycle, so a word can land whenever pop leaves <= 2 bytes.
  assign in_stream_tready = !eol_pending_q & ((cnt <= 3'd2) | ((cnt <= 3'd5) & fire));
  assign accept           = in_stream_tvalid & in_stream_tready;

  assign cnt_after_pop  = fire ? (cnt - 3'd3) : cnt;
  assign flush          = accept & in_stream_tuser & (cnt_after_pop != 3'd0);
  assign cnt_after_push = (flush ? 3'd0 : cnt_after_pop) + 3'd4;
  assign truncate       = accept & in_stream_tlast;

  always_comb begin
    sof_pending_d = sof_pending_q;
    eol_pending_d = eol_pending_q;
    x_d           = x_q;
    y_d           = y_q;
    err_d         = 1'b0;

    if (fire) begin
      if (eol != (x == X_LAST)) begin
        err_d = 1'b1;
      end
      // A lone sof+eol pixel ends line 0, so end-of-line takes precedence.
      if (eol) begin
        x_d = '0;
        y_d = (y == Y_LAST) ? '0 : y + 9'd1;
      end else if (sof) begin
        x_d = 10'd1;
        y_d = '0;
      end else begin
        x_d = x + 10'd1;
      end
      if (sof) begin
        sof_pending_d = 1'b0;
      end
      if (eol) begin
        eol_pending_d = 1'b0;
      end
    end

    if (accept) begin
      if (in_stream_tkeep != TKEEP_FULL) begin
        err_d = 1'b1;
      end
      if (in_stream_tuser) begin
        sof_pending_d = 1'b1;
      end
      if (flush) begin
        err_d = 1'b1;
      end
      if (in_stream_tlast) begin
        eol_pending_d = 1'b1;
        if (trunc3(cnt_after_push) != cnt_after_push) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sof_pending_q <= 1'b0;
      eol_pending_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      err_q         <= 1'b0;
    end else begin
      sof_pending_q <= sof_pending_d;
      eol_pending_q <= eol_pending_d;
      x_q           <= x_d;
      y_q           <= y_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
module tb_pixel_unpacker;

  localparam int XS = 640;
  localparam int YS = 3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] in_stream_tdata = '0;
  logic [3:0]  in_stream_tkeep = '0;
  logic        in_stream_tlast = 1'b0;
  logic        in_stream_tuser = 1'b0;
  logic        in_stream_tvalid = 1'b0;
  logic        in_stream_tready;
  logic [7:0]  r, g, b;
  logic        valid;
  logic        ready = 1'b0;
  logic        sof, eol;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        err;

  always #5 aclk = ~aclk;

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .in_stream_tdata  (in_stream_tdata),
    .in_stream_tkeep  (in_stream_tkeep),
    .in_stream_tlast  (in_stream_tlast),
    .in_stream_tuser  (in_stream_tuser),
    .in_stream_tvalid (in_stream_tvalid),
    .in_stream_tready (in_stream_tready),
    .r                (r),
    .g                (g),
    .b                (b),
    .valid            (valid),
    .ready            (ready),
    .sof              (sof),
    .eol              (eol),
    .x                (x),
    .y                (y),
    .err              (err)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    bit          user;
    bit          last;
  } word_t;

  int    errors = 0;
  int    checks = 0;
  word_t txq[$];
  bit    hold = 0;
  int    rdy_pct = 100;
  int    vld_pct = 100;
  int    bp_from = -100;

  // Reference model: a byte queue plus frame bookkeeping.
  logic [7:0] mq[$];
  bit  m_sofp, m_eolp, m_err;
  int  m_x, m_y;

  int  dut_pix, dut_eol, dut_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sofp = 0; m_eolp = 0; m_err = 0;
    m_x = 0; m_y = 0;
  endtask

  task automatic add_word(input logic [31:0] d, input logic [3:0] k, input bit u, input bit l);
    word_t w;
    w.data = d; w.keep = k; w.user = u; w.last = l;
    txq.push_back(w);
  endtask

  task automatic idle_inputs();
    in_stream_tvalid = 0; in_stream_tuser = 0; in_stream_tlast = 0;
    in_stream_tkeep = '0; in_stream_tdata = '0;
    hold = 0;
  endtask

  task automatic drive(input int n);
    if (n >= bp_from && n < bp_from + 5) ready = 0;
    else ready = ($urandom_range(99) < rdy_pct);
    if (!hold && txq.size() != 0 && $urandom_range(99) < vld_pct) hold = 1;
    if (hold) begin
      in_stream_tvalid = 1;
      in_stream_tdata  = txq[0].data;
      in_stream_tkeep  = txq[0].keep;
      in_stream_tuser  = txq[0].user;
      in_stream_tlast  = txq[0].last;
    end else begin
      in_stream_tvalid = 0;
      in_stream_tdata  = $urandom;
      in_stream_tkeep  = '0;
      in_stream_tuser  = 0;
      in_stream_tlast  = 0;
    end
  endtask

  // Called at posedge+1 with inputs driven; checks at mid-cycle, then advances the model.
  task automatic step(output bit acc);
    bit mv, msof, meol, mrdy, fire, e;
    int dx, dy;
    logic [31:0] d;
    #4;
    mv   = (mq.size() >= 3);
    msof = m_sofp && mv;
    meol = m_eolp && (mq.size() == 3);
    dx   = msof ? 0 : m_x;
    dy   = msof ? 0 : m_y;
    mrdy = !m_eolp && (mq.size() <= 2 || (mq.size() <= 5 && mv && ready));
    chk("valid", valid, mv);
    chk("tready", in_stream_tready, mrdy);
    chk("sof", sof, msof);
    chk("eol", eol, meol);
    chk("x", x, dx);
    chk("y", y, dy);
    chk("err", err, m_err);
    if (mv) begin
      chk("r", r, mq[0]);
      chk("g", g, mq[1]);
      chk("b", b, mq[2]);
    end
    if (valid && ready) dut_pix++;
    if (valid && ready && eol) dut_eol++;
    if (err) dut_errs++;

    fire = mv && ready;
    acc  = in_stream_tvalid && mrdy;
    e    = 0;
    if (fire) begin
      if (meol != (dx == XS - 1)) e = 1;
      repeat (3) void'(mq.pop_front());
      if (meol) begin
        m_x = 0;
        m_y = (dy == YS - 1) ? 0 : dy + 1;
      end else if (msof) begin
        m_x = 1;
        m_y = 0;
      end else begin
        m_x = (dx + 1) % 1024;
      end
      if (msof) m_sofp = 0;
      if (meol) m_eolp = 0;
    end
    if (acc) begin
      d = in_stream_tdata;
      if (in_stream_tkeep != 4'hF) e = 1;
      if (in_stream_tuser) begin
        if (mq.size() != 0) begin
          e = 1;
          mq.delete();
        end
        m_sofp = 1;
      end
      for (int i = 0; i < 4; i++) mq.push_back(d[8*i +: 8]);
      if (in_stream_tlast) begin
        m_eolp = 1;
        if (mq.size() % 3 != 0) e = 1;
        while (mq.size() % 3 != 0) void'(mq.pop_back());
      end
    end
    m_err = e;
    @(posedge aclk);
    #1;
  endtask

  task automatic run(input int max_cyc, input bit strict);
    int n;
    bit acc;
    n = 0;
    while ((txq.size() != 0 || mq.size() >= 3) && n < max_cyc) begin
      drive(n);
      step(acc);
      if (acc) begin
        void'(txq.pop_front());
        hold = 0;
      end
      n++;
    end
    if (strict) chk("drain_in_budget", 32'(n < max_cyc), 32'd1);
    idle_inputs();
    ready = 1;
  endtask

  task automatic add_line(input int nw, input bit first);
    for (int w = 0; w < nw; w++) add_word($urandom, 4'hF, first && w == 0, w == nw - 1);
  endtask

  initial begin
    bit acc;
    model_reset();
    idle_inputs();
    ready = 1;
    repeat (3) @(posedge aclk);
    #3;
    chk("reset_valid", valid, 0);
    chk("reset_tready", in_stream_tready, 1);
    chk("reset_err", err, 0);
    @(posedge aclk);
    #1;
    aresetn = 1;
    step(acc);
    step(acc);

    // Basic unpack
    add_word(32'h44332211, 4'hF, 1, 0);
    add_word(32'h88776655, 4'hF, 0, 0);
    add_word(32'hCCBBAA99, 4'hF, 0, 0);
    run(20, 1);
    step(acc);

    // Full line at full rate
    dut_pix = 0; dut_eol = 0; dut_errs = 0;
    add_line(480, 1);
    run(700, 1);
    step(acc);
    chk("line_pixels", dut_pix, 640);
    chk("line_eol_count", dut_eol, 1);
    chk("line_err_count", dut_errs, 0);
    chk("line_y_after", y, 1);

    // Back-pressure mid-line
    dut_pix = 0;
    bp_from = 6;
    add_line(12, 0);
    run(60, 1);
    bp_from = -100;
    step(acc);
    chk("bp_pixels", dut_pix, 16);

    // Misaligned tlast on a single tuser word
    dut_errs = 0;
    add_word(32'h04030201, 4'hF, 1, 1);
    run(20, 1);
    step(acc);
    chk("misaligned_err_pulses", dut_errs, 2);

    // Mid-line tuser discards the partial pixel
    add_word(32'h44332211, 4'hF, 1, 0);
    add_word(32'hDDCCBBAA, 4'hF, 1, 0);
    add_word(32'h11FFEE55, 4'hF, 0, 0);
    add_word(32'h55443322, 4'h7, 0, 1);
    run(30, 1);
    step(acc);

    // Random short lines, bad tkeep and stray tuser under random handshakes
    rdy_pct = 70; vld_pct = 70;
    for (int f = 0; f < 6; f++) begin
      int nl;
      nl = $urandom_range(4, 1);
      for (int l = 0; l < nl; l++) begin
        int nw;
        nw = $urandom_range(9, 1);
        for (int w = 0; w < nw; w++)
          add_word($urandom, ($urandom_range(19) == 0) ? 4'h7 : 4'hF,
                   (l == 0 && w == 0) || ($urandom_range(29) == 0), w == nw - 1);
      end
    end
    run(2000, 1);
    step(acc);

    // Full frame with row wrap
    rdy_pct = 85; vld_pct = 85;
    dut_errs = 0;
    add_line(480, 1);
    add_line(480, 0);
    add_line(480, 0);
    run(6000, 1);
    step(acc);
    chk("frame_err_count", dut_errs, 0);
    chk("frame_wrap_y", y, 0);
    rdy_pct = 100; vld_pct = 100;

    // Asynchronous reset mid-line
    add_line(30, 1);
    run(8, 0);
    txq.delete();
    idle_inputs();
    #2;
    aresetn = 0;
    #1;
    chk("async_valid", valid, 0);
    chk("async_tready", in_stream_tready, 1);
    model_reset();
    @(posedge aclk);
    #3;
    aresetn = 1;
    @(posedge aclk);
    #1;
    step(acc);
    add_word(32'h44332211, 4'hF, 1, 0);
    add_word(32'h88776655, 4'hF, 0, 0);
    add_word(32'hCCBBAA99, 4'hF, 0, 0);
    run(20, 1);
    step(acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
